bbox_scan: RTL and testbench

Raster-scan stage placed directly downstream of the bounding-box unit. Deserialises the four MSB-first 9-bit serial bounds (XMIN, XMAX, YMIN, YMAX), validates them, then walks every pixel in the inclusive box in row-major order. Emits one (x, y) coordinate per accepted transfer on a valid/ready handshake to the edge-test/shading stage.

---
 rtl/bbox_scan_pkg.sv | 18 +
 rtl/bbox_sipo9.sv | 30 +++
 rtl/bbox_scan.sv | 131 +++++++++++++
 tb/tb_bbox_scan.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/bbox_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module : bbox_scan_pkg
// Desc   : Shared widths and state encoding for the bounding-box raster scanner.
// Rev    : 1.0  initial release
// ============================================================================
package bbox_scan_pkg;
    localparam int COORD_W = 9;
    localparam int CNT_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CHECK = 2'd2,
        ST_SCAN  = 2'd3
    } state_t;
endpackage
`default_nettype wire

// File: rtl/bbox_sipo9.sv
`default_nettype none
// ============================================================================
// Module : bbox_sipo9
// Desc   : MSB-first serial-in/parallel-out shift register with load enable.
// Rev    : 1.0  initial release
// ============================================================================
module bbox_sipo9
    import bbox_scan_pkg::*;
#(
    parameter int WIDTH = COORD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_bit,
    output logic [WIDTH-1:0] o_q
);
    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= {r_q[WIDTH-2:0], i_bit};
        end
    end

    assign o_q = r_q;
endmodule
`default_nettype wire

// File: rtl/bbox_scan.sv
`default_nettype none
// ============================================================================
// Module : bbox_scan
// Desc   : Deserialises four bounds, validates them and raster-scans the box.
// Rev    : 1.0  initial release
// ============================================================================
module bbox_scan
    import bbox_scan_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic               i_xmin,
    input  logic               i_xmax,
    input  logic               i_ymin,
    input  logic               i_ymax,
    input  logic               i_pready,
    output logic [COORD_W-1:0] o_px,
    output logic [COORD_W-1:0] o_py,
    output logic               o_pvalid,
    output logic               o_plast,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err
);
    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [COORD_W-1:0] r_px;
    logic [COORD_W-1:0] r_py;
    logic               r_pvalid;
    logic               r_busy;
    logic               r_done;
    logic               r_err;

    logic               w_shift_en;
    logic [3:0]         w_bits;
    logic [COORD_W-1:0] w_bound [4];
    logic [COORD_W-1:0] w_xmin, w_xmax, w_ymin, w_ymax;
    logic               w_plast;

    // The MSB is captured on the START edge itself, so shifting begins in IDLE.
    assign w_shift_en = ((r_state == ST_IDLE) && i_start) || (r_state == ST_LOAD);
    assign w_bits     = {i_ymax, i_ymin, i_xmax, i_xmin};

    generate
        for (genvar g = 0; g < 4; g++) begin : g_sipo
            bbox_sipo9 #(.WIDTH(COORD_W)) u_sipo (
                .clk   (clk),
                .rst_n (rst_n),
                .i_en  (w_shift_en),
                .i_bit (w_bits[g]),
                .o_q   (w_bound[g])
            );
        end
    endgenerate

    assign w_xmin  = w_bound[0];
    assign w_xmax  = w_bound[1];
    assign w_ymin  = w_bound[2];
    assign w_ymax  = w_bound[3];
    assign w_plast = r_pvalid && (r_px == w_xmax) && (r_py == w_ymax);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_px     <= '0;
            r_py     <= '0;
            r_pvalid <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_cnt   <= CNT_W'(1);
                        r_busy  <= 1'b1;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(8)) begin
                        r_state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if ((w_xmin > w_xmax) || (w_ymin > w_ymax)) begin
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_px     <= w_xmin;
                        r_py     <= w_ymin;
                        r_pvalid <= 1'b1;
                        r_state  <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    // Equality is tested before incrementing so 511 never wraps.
                    if (i_pready) begin
                        if (w_plast) begin
                            r_pvalid <= 1'b0;
                            r_done   <= 1'b1;
                            r_busy   <= 1'b0;
                            r_state  <= ST_IDLE;
                        end else if (r_px != w_xmax) begin
                            r_px <= r_px + COORD_W'(1);
                        end else begin
                            r_px <= w_xmin;
                            r_py <= r_py + COORD_W'(1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_px     = r_px;
    assign o_py     = r_py;
    assign o_pvalid = r_pvalid;
    assign o_plast  = w_plast;
    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_err    = r_err;
endmodule
`default_nettype wire

// File: tb/tb_bbox_scan.sv
`default_nettype none
// ============================================================================
// Module : tb_bbox_scan
// Desc   : Self-checking bench for bbox_scan against a nested-loop pixel model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_bbox_scan;
    import bbox_scan_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               i_start = 1'b0;
    logic               i_xmin = 1'b0;
    logic               i_xmax = 1'b0;
    logic               i_ymin = 1'b0;
    logic               i_ymax = 1'b0;
    logic               i_pready = 1'b1;
    logic [COORD_W-1:0] o_px;
    logic [COORD_W-1:0] o_py;
    logic               o_pvalid;
    logic               o_plast;
    logic               o_busy;
    logic               o_done;
    logic               o_err;

    int n_tests = 0;
    int n_fail  = 0;

    bbox_scan u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (i_start),
        .i_xmin   (i_xmin),
        .i_xmax   (i_xmax),
        .i_ymin   (i_ymin),
        .i_ymax   (i_ymax),
        .i_pready (i_pready),
        .o_px     (o_px),
        .o_py     (o_py),
        .o_pvalid (o_pvalid),
        .o_plast  (o_plast),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_err    (o_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Serialise the four bounds MSB first; START accompanies bit 8.
    task automatic load_box(input int xmn, input int xmx, input int ymn, input int ymx);
        logic [8:0] a, b, c, d;
        a = 9'(xmn); b = 9'(xmx); c = 9'(ymn); d = 9'(ymx);
        for (int i = 8; i >= 0; i--) begin
            @(negedge clk);
            if (i == 7) chk("busy_after_start", o_busy, 1);
            i_start = (i == 8);
            i_xmin  = a[i];
            i_xmax  = b[i];
            i_ymin  = c[i];
            i_ymax  = d[i];
        end
        @(posedge clk);
    endtask

    task automatic run_box(input int xmn, input int xmx, input int ymn, input int ymx,
                           input int mode, input bit inject_start);
        int qx[$];
        int qy[$];
        int cyc;
        bit is_err;
        bit pat[5];
        pat = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        is_err = (xmn > xmx) || (ymn > ymx);
        if (!is_err) begin
            for (int y = ymn; y <= ymx; y++)
                for (int x = xmn; x <= xmx; x++) begin
                    qx.push_back(x);
                    qy.push_back(y);
                end
        end
        i_pready = 1'b1;
        load_box(xmn, xmx, ymn, ymx);
        @(negedge clk);
        i_start = 1'b0;
        chk("check_cycle_pvalid", o_pvalid, 0);
        chk("check_cycle_busy", o_busy, 1);
        @(negedge clk);
        if (is_err) begin
            chk("err_pulse", o_err, 1);
            chk("err_pvalid", o_pvalid, 0);
            chk("err_busy", o_busy, 0);
            @(negedge clk);
            chk("err_clear", o_err, 0);
            chk("err_pvalid_after", o_pvalid, 0);
            return;
        end
        chk("first_pvalid", o_pvalid, 1);
        chk("no_err", o_err, 0);
        cyc = 0;
        while (qx.size() > 0 && cyc < 400) begin
            case (mode)
                0:       i_pready = 1'b1;
                1:       i_pready = 1'($urandom_range(0, 1));
                default: i_pready = (cyc < 5) ? pat[cyc] : 1'b1;
            endcase
            if (inject_start && cyc == 2) begin
                i_start = 1'b1;
                i_xmin  = 1'($urandom_range(0, 1));
                i_xmax  = 1'($urandom_range(0, 1));
                i_ymin  = 1'($urandom_range(0, 1));
                i_ymax  = 1'($urandom_range(0, 1));
            end else begin
                i_start = 1'b0;
            end
            chk("pvalid", o_pvalid, 1);
            chk("px", o_px, qx[0]);
            chk("py", o_py, qy[0]);
            chk("plast", o_plast, (qx.size() == 1));
            chk("busy_scan", o_busy, 1);
            if (i_pready) begin
                void'(qx.pop_front());
                void'(qy.pop_front());
            end
            cyc++;
            @(negedge clk);
        end
        i_start = 1'b0;
        if (qx.size() > 0) chk("scan_timeout_pixels_left", qx.size(), 0);
        chk("done_pulse", o_done, 1);
        chk("done_pvalid", o_pvalid, 0);
        chk("done_busy", o_busy, 0);
        @(negedge clk);
        chk("done_clear", o_done, 0);
        chk("idle_pvalid", o_pvalid, 0);
    endtask

    initial begin
        int xmn, xmx, ymn, ymx;
        #3;
        chk("rst_px", o_px, 0);
        chk("rst_py", o_py, 0);
        chk("rst_pvalid", o_pvalid, 0);
        chk("rst_plast", o_plast, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_err", o_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_box(3, 5, 10, 11, 0, 1'b0);
        run_box(7, 7, 7, 7, 0, 1'b0);
        run_box(509, 511, 511, 511, 0, 1'b0);
        run_box(20, 10, 0, 0, 0, 1'b0);
        chk("busy_after_err", o_busy, 0);
        run_box(0, 1, 0, 0, 2, 1'b0);
        run_box(100, 103, 50, 51, 0, 1'b1);

        // Asynchronous reset in the middle of a scan.
        load_box(0, 3, 0, 3);
        repeat (4) @(negedge clk);
        chk("pre_reset_pvalid", o_pvalid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_px", o_px, 0);
        chk("arst_py", o_py, 0);
        chk("arst_pvalid", o_pvalid, 0);
        chk("arst_plast", o_plast, 0);
        chk("arst_busy", o_busy, 0);
        chk("arst_done", o_done, 0);
        chk("arst_err", o_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_box(2, 4, 6, 7, 0, 1'b0);

        for (int k = 0; k < 10; k++) begin
            if (k % 4 == 3) begin
                xmx = $urandom_range(0, 510);
                xmn = $urandom_range(xmx + 1, 511);
                ymn = $urandom_range(0, 511);
                ymx = ymn;
            end else begin
                xmn = $urandom_range(0, 511);
                xmx = xmn + $urandom_range(0, 3);
                if (xmx > 511) xmx = 511;
                ymn = $urandom_range(0, 511);
                ymx = ymn + $urandom_range(0, 2);
                if (ymx > 511) ymx = 511;
            end
            run_box(xmn, xmx, ymn, ymx, 1, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
